// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants for the register-file write-back arbiter: state encodings,
// requester IDs and default widths.
package regfile_wb_arbiter_pkg;

    localparam int unsigned DEFAULT_DATA_W = 32;
    localparam int unsigned DEFAULT_ADDR_W = 5;

    localparam logic [0:0] INIT = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic REQ_ALU = 1'b0;
    localparam logic REQ_LSU = 1'b1;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between the write-back requesters, the arbiter and the register-file
// write port.
interface regfile_wb_arbiter_if
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W
);

    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;
    logic              lsu_valid;
    logic              lsu_ready;
    logic [ADDR_W-1:0] lsu_addr;
    logic [DATA_W-1:0] lsu_data;
    logic              WE3;
    logic [ADDR_W-1:0] A3;
    logic [DATA_W-1:0] WD3;
    logic              init_done;
    logic              grant_id;

    modport slave (
        input  alu_valid, alu_addr, alu_data, lsu_valid, lsu_addr, lsu_data,
        output alu_ready, lsu_ready, WE3, A3, WD3, init_done, grant_id
    );

    modport master (
        output alu_valid, alu_addr, alu_data, lsu_valid, lsu_addr, lsu_data,
        input  alu_ready, lsu_ready, WE3, A3, WD3, init_done, grant_id
    );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter2.sv
// Two-input round-robin arbiter; the pointer names the requester favoured on a tie
// and moves only when a grant is issued.
module rr_arbiter2
    import regfile_wb_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic ptr_q;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req[0] && (!req[1] || ptr_q == REQ_ALU)) begin
                gnt[0] = 1'b1;
            end else if (req[1]) begin
                gnt[1] = 1'b1;
            end
        end
    end

    // A grant always completes a transfer, since ready is the grant itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= REQ_ALU;
        end else if (gnt[0]) begin
            ptr_q <= REQ_LSU;
        end else if (gnt[1]) begin
            ptr_q <= REQ_ALU;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter: clears every register after reset, then merges
// ALU and load-unit write-backs onto a single registered write port.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W      = DEFAULT_DATA_W,
    parameter int unsigned ADDR_W      = DEFAULT_ADDR_W,
    parameter bit          ZERO_REG_RO = 1'b1
) (
    input logic                 clk,
    input logic                 rst_n,
    regfile_wb_arbiter_if.slave bus
);

    localparam logic [ADDR_W-1:0] IDX_MAX = '1;

    logic [0:0]        state_q;
    logic [ADDR_W-1:0] idx_q;
    logic              we_q;
    logic [ADDR_W-1:0] a3_q;
    logic [DATA_W-1:0] wd3_q;
    logic              grant_q;
    logic              done_q;

    logic [1:0]        gnt;
    logic              xfer;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_q == RUN),
        .req   ({bus.lsu_valid, bus.alu_valid}),
        .gnt   (gnt)
    );

    assign bus.alu_ready = gnt[0];
    assign bus.lsu_ready = gnt[1];

    assign xfer     = |gnt;
    assign win_addr = gnt[1] ? bus.lsu_addr : bus.alu_addr;
    assign win_data = gnt[1] ? bus.lsu_data : bus.alu_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT;
            idx_q   <= '0;
            we_q    <= 1'b0;
            a3_q    <= '0;
            wd3_q   <= '0;
            grant_q <= REQ_ALU;
            done_q  <= 1'b0;
        end else if (state_q == INIT) begin
            we_q  <= 1'b1;
            a3_q  <= idx_q;
            wd3_q <= '0;
            idx_q <= idx_q + 1'b1;
            if (idx_q == IDX_MAX) begin
                state_q <= RUN;
                done_q  <= 1'b1;
            end
        end else if (xfer) begin
            // Writes to r0 still complete the handshake but never reach the file.
            we_q    <= !(ZERO_REG_RO && (win_addr == '0));
            a3_q    <= win_addr;
            wd3_q   <= win_data;
            grant_q <= gnt[1];
        end else begin
            we_q <= 1'b0;
        end
    end

    assign bus.WE3       = we_q;
    assign bus.A3        = a3_q;
    assign bus.WD3       = wd3_q;
    assign bus.grant_id  = grant_q;
    assign bus.init_done = done_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: clear sweep, hold-off during INIT,
// round-robin alternation, r0 write discard and reset abort.
module tb_regfile_wb_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();
    regfile_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus0 ();

    regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .ZERO_REG_RO(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .ZERO_REG_RO(1'b0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.alu_valid = 1'b0; bus.alu_addr = '0; bus.alu_data = '0;
        bus.lsu_valid = 1'b0; bus.lsu_addr = '0; bus.lsu_data = '0;
        bus0.alu_valid = 1'b0; bus0.alu_addr = '0; bus0.alu_data = '0;
        bus0.lsu_valid = 1'b0; bus0.lsu_addr = '0; bus0.lsu_data = '0;
    endtask

    task automatic reset_and_sweep();
        rst_n = 1'b0;
        #3;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (33) tick();
    endtask

    // Checks the 32-write clear sweep following a reset release at a negedge.
    task automatic check_sweep(input string tag);
        for (int k = 1; k <= 32; k++) begin
            tick();
            checks++;
            if (bus.WE3 !== 1'b1 || bus.A3 !== 5'(k - 1) || bus.WD3 !== 32'h0) begin
                errors++;
                $display("FAIL %s sweep[%0d]: WE3=%b A3=%0d WD3=%h, want WE3=1 A3=%0d WD3=0",
                         tag, k, bus.WE3, bus.A3, bus.WD3, k - 1);
            end
            if (k < 32) begin
                checks++;
                if (bus.init_done !== 1'b0) begin
                    errors++;
                    $display("FAIL %s init_done early at %0d: got %b want 0", tag, k,
                             bus.init_done);
                end
            end
        end
        tick();
        checks++;
        if (bus.WE3 !== 1'b0 || bus.init_done !== 1'b1) begin
            errors++;
            $display("FAIL %s sweep end: WE3=%b init_done=%b, want WE3=0 init_done=1",
                     tag, bus.WE3, bus.init_done);
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        #1 rst_n = 1'b0;
        #2;
        bus.alu_valid = 1'b1;
        bus.lsu_valid = 1'b1;
        #1;
        checks++;
        if (bus.WE3 !== 1'b0 || bus.A3 !== 5'd0 || bus.WD3 !== 32'h0) begin
            errors++;
            $display("FAIL reset port: WE3=%b A3=%0d WD3=%h, want 0 0 0", bus.WE3, bus.A3, bus.WD3);
        end
        checks++;
        if (bus.init_done !== 1'b0 || bus.grant_id !== 1'b0) begin
            errors++;
            $display("FAIL reset flags: init_done=%b grant_id=%b, want 0 0",
                     bus.init_done, bus.grant_id);
        end
        tick();
        checks++;
        if (bus.alu_ready !== 1'b0 || bus.lsu_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset ready: alu=%b lsu=%b, want 0 0", bus.alu_ready, bus.lsu_ready);
        end
        clear_inputs();
    endtask

    task automatic test_init_sweep();
        @(negedge clk);
        rst_n = 1'b1;
        check_sweep("init");
    endtask

    task automatic test_init_hold();
        rst_n = 1'b0;
        #3;
        bus.alu_valid = 1'b1;
        bus.alu_addr  = 5'd3;
        bus.alu_data  = 32'hDEADBEEF;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            tick();
            checks++;
            if (bus.alu_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold alu_ready[%0d]: got %b want 0", k, bus.alu_ready);
            end
        end
        tick();
        checks++;
        if (bus.alu_ready !== 1'b1 || bus.lsu_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold first run: alu_ready=%b lsu_ready=%b, want 1 0",
                     bus.alu_ready, bus.lsu_ready);
        end
        tick();
        checks++;
        if (bus.WE3 !== 1'b1 || bus.A3 !== 5'd3 || bus.WD3 !== 32'hDEADBEEF ||
            bus.grant_id !== 1'b0) begin
            errors++;
            $display("FAIL hold write: WE3=%b A3=%0d WD3=%h gid=%b, want 1 3 deadbeef 0",
                     bus.WE3, bus.A3, bus.WD3, bus.grant_id);
        end
        bus.alu_valid = 1'b0;
        tick();
        checks++;
        if (bus.WE3 !== 1'b0 || bus.A3 !== 5'd3 || bus.WD3 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL hold idle: WE3=%b A3=%0d WD3=%h, want 0 3 deadbeef",
                     bus.WE3, bus.A3, bus.WD3);
        end
    endtask

    task automatic test_round_robin();
        logic exp_lsu;
        reset_and_sweep();
        bus.alu_valid = 1'b1; bus.alu_addr = 5'd1; bus.alu_data = 32'hA1A1_0001;
        bus.lsu_valid = 1'b1; bus.lsu_addr = 5'd2; bus.lsu_data = 32'hB2B2_0002;
        #1;
        checks++;
        if (bus.alu_ready !== 1'b1 || bus.lsu_ready !== 1'b0) begin
            errors++;
            $display("FAIL rr first ready: alu=%b lsu=%b, want 1 0", bus.alu_ready, bus.lsu_ready);
        end
        for (int k = 0; k < 6; k++) begin
            exp_lsu = (k % 2) == 1;
            tick();
            checks++;
            if (bus.WE3 !== 1'b1 || bus.grant_id !== exp_lsu ||
                bus.A3 !== (exp_lsu ? 5'd2 : 5'd1) ||
                bus.WD3 !== (exp_lsu ? 32'hB2B2_0002 : 32'hA1A1_0001)) begin
                errors++;
                $display("FAIL rr grant[%0d]: WE3=%b gid=%b A3=%0d WD3=%h, want gid=%b",
                         k, bus.WE3, bus.grant_id, bus.A3, bus.WD3, exp_lsu);
            end
        end
        clear_inputs();
        tick();
        checks++;
        if (bus.WE3 !== 1'b0) begin
            errors++;
            $display("FAIL rr idle: WE3=%b want 0", bus.WE3);
        end
    endtask

    task automatic test_zero_reg();
        bus.lsu_valid = 1'b1;  bus.lsu_addr = 5'd0;  bus.lsu_data = 32'h1234;
        bus0.lsu_valid = 1'b1; bus0.lsu_addr = 5'd0; bus0.lsu_data = 32'h1234;
        #1;
        checks++;
        if (bus.lsu_ready !== 1'b1 || bus0.lsu_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero ready: ro=%b rw=%b, want 1 1", bus.lsu_ready, bus0.lsu_ready);
        end
        tick();
        clear_inputs();
        checks++;
        if (bus.WE3 !== 1'b0) begin
            errors++;
            $display("FAIL zero ro WE3: got %b want 0", bus.WE3);
        end
        checks++;
        if (bus0.WE3 !== 1'b1 || bus0.A3 !== 5'd0 || bus0.WD3 !== 32'h1234 ||
            bus0.grant_id !== 1'b1) begin
            errors++;
            $display("FAIL zero rw write: WE3=%b A3=%0d WD3=%h gid=%b, want 1 0 1234 1",
                     bus0.WE3, bus0.A3, bus0.WD3, bus0.grant_id);
        end
        tick();
        checks++;
        if (bus0.WE3 !== 1'b0 || bus0.WD3 !== 32'h1234) begin
            errors++;
            $display("FAIL zero rw idle: WE3=%b WD3=%h, want 0 1234", bus0.WE3, bus0.WD3);
        end
    endtask

    task automatic test_lsu_then_both();
        reset_and_sweep();
        bus.lsu_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.lsu_addr = 5'(5 + k);
            bus.lsu_data = 32'h50 + 32'(k);
            tick();
            checks++;
            if (bus.WE3 !== 1'b1 || bus.grant_id !== 1'b1 || bus.A3 !== 5'(5 + k) ||
                bus.WD3 !== 32'h50 + 32'(k)) begin
                errors++;
                $display("FAIL lsu only[%0d]: WE3=%b gid=%b A3=%0d WD3=%h, want 1 1 %0d %h",
                         k, bus.WE3, bus.grant_id, bus.A3, bus.WD3, 5 + k, 32'h50 + 32'(k));
            end
        end
        bus.alu_valid = 1'b1; bus.alu_addr = 5'd9;  bus.alu_data = 32'h99;
        bus.lsu_addr  = 5'd10; bus.lsu_data = 32'hAA;
        #1;
        checks++;
        if (bus.alu_ready !== 1'b1 || bus.lsu_ready !== 1'b0) begin
            errors++;
            $display("FAIL both after lsu: alu=%b lsu=%b, want 1 0", bus.alu_ready, bus.lsu_ready);
        end
        tick();
        checks++;
        if (bus.grant_id !== 1'b0 || bus.A3 !== 5'd9 || bus.WD3 !== 32'h99) begin
            errors++;
            $display("FAIL both grant: gid=%b A3=%0d WD3=%h, want 0 9 99",
                     bus.grant_id, bus.A3, bus.WD3);
        end
        clear_inputs();
        repeat (3) tick();
        checks++;
        if (bus.WE3 !== 1'b0) begin
            errors++;
            $display("FAIL idle gap WE3: got %b want 0", bus.WE3);
        end
        // Idle cycles must not move the pointer: LSU is owed the next tie.
        bus.alu_valid = 1'b1; bus.alu_addr = 5'd9;  bus.alu_data = 32'h99;
        bus.lsu_valid = 1'b1; bus.lsu_addr = 5'd10; bus.lsu_data = 32'hAA;
        #1;
        checks++;
        if (bus.alu_ready !== 1'b0 || bus.lsu_ready !== 1'b1) begin
            errors++;
            $display("FAIL after idle: alu=%b lsu=%b, want 0 1", bus.alu_ready, bus.lsu_ready);
        end
        tick();
        checks++;
        if (bus.grant_id !== 1'b1 || bus.A3 !== 5'd10 || bus.WD3 !== 32'hAA) begin
            errors++;
            $display("FAIL after idle grant: gid=%b A3=%0d WD3=%h, want 1 10 aa",
                     bus.grant_id, bus.A3, bus.WD3);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_mid_init_reset();
        rst_n = 1'b0;
        #3;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (17) tick();
        checks++;
        if (bus.A3 !== 5'd16 || bus.WE3 !== 1'b1) begin
            errors++;
            $display("FAIL mid init pre: A3=%0d WE3=%b, want 16 1", bus.A3, bus.WE3);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.WE3 !== 1'b0 || bus.A3 !== 5'd0 || bus.WD3 !== 32'h0 ||
            bus.init_done !== 1'b0) begin
            errors++;
            $display("FAIL mid init async: WE3=%b A3=%0d WD3=%h done=%b, want 0 0 0 0",
                     bus.WE3, bus.A3, bus.WD3, bus.init_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        check_sweep("restart");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        clear_inputs();
        test_reset();
        test_init_sweep();
        test_init_hold();
        test_round_robin();
        test_zero_reg();
        test_lsu_then_both();
        test_mid_init_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
